// File: rtl/serial_alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: op encodings,
// alu_ctl field positions, named control codes and FSM states.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_ADD = 2'd2,
        OP_SLT = 2'd3
    } alu_op_e;

    // alu_ctl = {Ainvert, Binvert, op[1:0]}
    localparam int unsigned CTL_AINV_BIT = 3;
    localparam int unsigned CTL_BINV_BIT = 2;
    localparam int unsigned CTL_OP_MSB   = 1;
    localparam int unsigned CTL_OP_LSB   = 0;

    localparam logic [3:0] ALU_CTL_AND = 4'b0000;
    localparam logic [3:0] ALU_CTL_OR  = 4'b0001;
    localparam logic [3:0] ALU_CTL_ADD = 4'b0010;
    localparam logic [3:0] ALU_CTL_SUB = 4'b0110;
    localparam logic [3:0] ALU_CTL_SLT = 4'b0111;
    localparam logic [3:0] ALU_CTL_NOR = 4'b1100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        SLT_FIX = 2'd2,
        DONE    = 2'd3
    } state_e;

    // ADD and SLT run the adder chain and report carry/overflow
    function automatic logic op_is_arith(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/serial_alu_seq_if.sv
// Operand/result handshake bundle for serial_alu_seq.
// master: producer of operands and consumer of results; slave: the ALU.
interface serial_alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_ctl;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             c_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, alu_ctl, out_ready,
        input  in_ready, out_valid, result, zero, c_out, overflow
    );

    modport slave (
        input  in_valid, a, b, alu_ctl, out_ready,
        output in_ready, out_valid, result, zero, c_out, overflow
    );
endinterface

// File: rtl/serial_alu_seq_cell.sv
// Combinational 1-bit ALU slice. Besides result/c_out it exposes the raw
// sum bit as 'set', which the MSB position uses to form the SLT flag.
module serial_alu_cell
    import serial_alu_pkg::*;
(
    input  logic    a,
    input  logic    b,
    input  logic    less,
    input  logic    a_invert,
    input  logic    b_invert,
    input  logic    c_in,
    input  alu_op_e op,
    output logic    result,
    output logic    c_out,
    output logic    set
);

    logic a_eff;
    logic b_eff;
    logic sum;

    // Invert operands, full-add, then select the per-op result bit
    always_comb begin
        a_eff  = a ^ a_invert;
        b_eff  = b ^ b_invert;
        sum    = a_eff ^ b_eff ^ c_in;
        c_out  = (a_eff & b_eff) | (a_eff & c_in) | (b_eff & c_in);
        set    = sum;
        result = 1'b0;
        unique case (op)
            OP_AND: result = a_eff & b_eff;
            OP_OR:  result = a_eff | b_eff;
            OP_ADD: result = sum;
            OP_SLT: result = less;
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: latches operands on a valid/ready handshake,
// drives one serial_alu_cell LSB-first for WIDTH cycles with the carry
// looped back, back-fills SLT, and holds a registered result plus flags
// until the consumer accepts it.
// Optional: define SERIAL_ALU_SLT_OVF_FIX_EN to make SLT signed-correct
// (set = MSB sum xor overflow); otherwise set = MSB sum bit.
module serial_alu_seq
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_alu_seq_if.slave  bus
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       ctl_q, ctl_d;
    logic             carry_q, carry_d;
    logic [WIDTH-2:0] acc_q, acc_d;
    logic             set_q, set_d;
    logic             cfin_q, cfin_d;
    logic             ofin_q, ofin_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             c_out_q, c_out_d;
    logic             overflow_q, overflow_d;

    alu_op_e          op;
    logic             cell_res;
    logic             cell_cout;
    logic             cell_set;
    logic [WIDTH-1:0] acc_ext;
    logic             ovf_now;
    logic             set_now;

    assign op = alu_op_e'(ctl_q[CTL_OP_MSB:CTL_OP_LSB]);

    // Operands are shifted right each RUN cycle, so bit 0 is always the current bit
    serial_alu_cell u_cell (
        .a        (a_q[0]),
        .b        (b_q[0]),
        .less     (1'b0),
        .a_invert (ctl_q[CTL_AINV_BIT]),
        .b_invert (ctl_q[CTL_BINV_BIT]),
        .c_in     (carry_q),
        .op       (op),
        .result   (cell_res),
        .c_out    (cell_cout),
        .set      (cell_set)
    );

    // Next-state and next-output computation for the sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        ctl_d       = ctl_q;
        carry_d     = carry_q;
        acc_d       = acc_q;
        set_d       = set_q;
        cfin_d      = cfin_q;
        ofin_d      = ofin_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        c_out_d     = c_out_q;
        overflow_d  = overflow_q;

        // Result bits enter at the top; after WIDTH bits the word is in order
        acc_ext = {cell_res, acc_q};
        ovf_now = carry_q ^ cell_cout;
`ifdef SERIAL_ALU_SLT_OVF_FIX_EN
        set_now = cell_set ^ ovf_now;
`else
        set_now = cell_set;
`endif

        unique case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d        = bus.a;
                    b_d        = bus.b;
                    ctl_d      = bus.alu_ctl;
                    carry_d    = bus.alu_ctl[CTL_BINV_BIT];
                    cnt_d      = '0;
                    acc_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end

            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                acc_d = acc_ext[WIDTH-1:1];
                cnt_d = cnt_q + CW'(1);
                if (op_is_arith(op)) begin
                    carry_d = cell_cout;
                end
                if (cnt_q == CNT_LAST) begin
                    if (op == OP_SLT) begin
                        // Flags are staged so outputs stay put until DONE
                        cfin_d  = cell_cout;
                        ofin_d  = ovf_now;
                        set_d   = set_now;
                        state_d = SLT_FIX;
                    end else begin
                        result_d    = acc_ext;
                        zero_d      = (acc_ext == '0);
                        c_out_d     = op_is_arith(op) ? cell_cout : 1'b0;
                        overflow_d  = op_is_arith(op) ? ovf_now : 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end

            SLT_FIX: begin
                result_d    = WIDTH'(set_q);
                zero_d      = ~set_q;
                c_out_d     = cfin_q;
                overflow_d  = ofin_q;
                out_valid_d = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ctl_q       <= '0;
            carry_q     <= 1'b0;
            acc_q       <= '0;
            set_q       <= 1'b0;
            cfin_q      <= 1'b0;
            ofin_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            c_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctl_q       <= ctl_d;
            carry_q     <= carry_d;
            acc_q       <= acc_d;
            set_q       <= set_d;
            cfin_q      <= cfin_d;
            ofin_q      <= ofin_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            c_out_q     <= c_out_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.c_out     = c_out_q;
    assign bus.overflow  = overflow_q;

endmodule
